// File: rtl/cos_horner_seq.sv
// Sequenced cos(x) Horner evaluator driving one external combinational multiplier.
// Define COS_SAT_EN to saturate the re-quantizer and the Horner add; default build wraps.
module cos_horner_seq #(
  parameter int WI = 4,
  parameter int WF = 16,
  parameter int C0 = 65536,
  parameter int C1 = -32768,
  parameter int C2 = 2731,
  parameter int C3 = -91
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [WI+WF-1:0]       x_in,
  output logic signed [WI+WF-1:0]       mul_a,
  output logic signed [WI+WF-1:0]       mul_b,
  input  logic signed [2*(WI+WF)-1:0]   mul_p,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [WI+WF-1:0]       cos_out
);

  localparam int W  = WI + WF;
  localparam int PW = 2 * W;

  localparam logic signed [W-1:0]  K0      = W'(C0);
  localparam logic signed [W-1:0]  K1      = W'(C1);
  localparam logic signed [W-1:0]  K2      = W'(C2);
  localparam logic signed [W-1:0]  K3      = W'(C3);
  localparam logic signed [PW-1:0] RndHalf = PW'(1) << (WF - 1);

  typedef enum logic [1:0] {StIdle, StSqr, StHorn, StDone} state_e;

  state_e              state;
  logic signed [W-1:0] z;
  logic signed [W-1:0] acc;
  logic [1:0]          k;

  logic signed [PW-1:0] p_shr;
  logic signed [W-1:0]  rq_val;
  logic signed [W-1:0]  coef;
  logic signed [W-1:0]  horn_sum;

  // Round half up, then drop the fractional bits of the Q8.32 product.
  assign p_shr = (mul_p + RndHalf) >>> WF;

  always_comb begin
    coef = K0;
    case (k)
      2'd2:    coef = K2;
      2'd1:    coef = K1;
      default: coef = K0;
    endcase
  end

`ifdef COS_SAT_EN
  localparam logic signed [PW-1:0] PMax = PW'((1 << (W - 1)) - 1);
  localparam logic signed [PW-1:0] PMin = ~PMax;

  logic [W:0] sum_ext;

  always_comb begin
    if (p_shr > PMax) begin
      rq_val = {1'b0, {(W-1){1'b1}}};
    end else if (p_shr < PMin) begin
      rq_val = {1'b1, {(W-1){1'b0}}};
    end else begin
      rq_val = p_shr[W-1:0];
    end
    sum_ext = {rq_val[W-1], rq_val} + {coef[W-1], coef};
    // Sign bits disagree only on overflow; the top bit gives the direction.
    if (sum_ext[W] != sum_ext[W-1]) begin
      horn_sum = sum_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      horn_sum = sum_ext[W-1:0];
    end
  end
`else
  logic unused_shr_hi;
  assign unused_shr_hi = ^p_shr[PW-1:W];
  assign rq_val        = p_shr[W-1:0];
  assign horn_sum      = rq_val + coef;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cos_out   <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      z         <= '0;
      acc       <= '0;
      k         <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid && in_ready) begin
            mul_a    <= x_in;
            mul_b    <= x_in;
            in_ready <= 1'b0;
            state    <= StSqr;
          end
        end
        StSqr: begin
          z     <= rq_val;
          mul_a <= K3;
          mul_b <= rq_val;
          acc   <= K3;
          k     <= 2'd2;
          state <= StHorn;
        end
        StHorn: begin
          acc   <= horn_sum;
          mul_a <= horn_sum;
          mul_b <= z;
          if (k == 2'd0) begin
            cos_out   <= horn_sum;
            out_valid <= 1'b1;
            state     <= StDone;
          end else begin
            k <= k - 2'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cos_horner_seq.sv
// Directed bench for cos_horner_seq with a combinational multiplier model on mul_a/mul_b.
module tb_cos_horner_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] x_in;
  logic signed [19:0] mul_a;
  logic signed [19:0] mul_b;
  logic signed [39:0] mul_p;
  logic               out_valid;
  logic               out_ready;
  logic signed [19:0] cos_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign mul_p = mul_a * mul_b;

  cos_horner_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_out   (cos_out)
  );

  typedef struct {
    logic [19:0] x;
    logic [19:0] exp;
  } vec_t;

  task automatic check_v(input string name, input logic [19:0] act, input logic [19:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %05h, expected %05h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [19:0] rq_m(input longint p);
    longint s;
    s = (p + 64'sd32768) >>> 16;
`ifdef COS_SAT_EN
    if (s > 524287) s = 524287;
    else if (s < -524288) s = -524288;
`endif
    return s[19:0];
  endfunction

  function automatic logic [19:0] add_m(input logic [19:0] a, input longint c);
    longint s;
    s = longint'($signed(a)) + c;
`ifdef COS_SAT_EN
    if (s > 524287) s = 524287;
    else if (s < -524288) s = -524288;
`endif
    return s[19:0];
  endfunction

  function automatic logic [19:0] cos_m(input logic [19:0] x);
    longint      xs;
    longint      cs [3];
    logic [19:0] z;
    logic [19:0] acc;
    cs  = '{2731, -32768, 65536};
    xs  = longint'($signed(x));
    z   = rq_m(xs * xs);
    acc = 20'hFFFA5;
    for (int i = 0; i < 3; i++) begin
      acc = add_m(rq_m(longint'($signed(acc)) * longint'($signed(z))), cs[i]);
    end
    return acc;
  endfunction

  // Called just after a posedge while idle; returns just after the accept edge.
  task automatic drive_accept(input logic [19:0] x);
    in_valid = 1'b1;
    x_in     = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // lat = index of the first edge (counted from the call) at which out_valid is seen high.
  task automatic wait_done(output logic [19:0] res, output int lat);
    lat = -1;
    res = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        res = cos_out;
        break;
      end
    end
    if (lat < 0) $display("FAIL wait_done: out_valid not seen within 20 cycles");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [5];
    logic [19:0] res;
    int          lat;
    int          first;
    int          second;
    logic        prev;
    logic        held;
    logic        seen;

    vecs[0] = '{x: 20'h00000, exp: 20'h10000};
    vecs[1] = '{x: 20'h10000, exp: 20'h08A50};
    vecs[2] = '{x: 20'hF0000, exp: 20'h08A50};
    vecs[3] = '{x: 20'h08000, exp: 20'h0E0A9};
    vecs[4] = '{x: 20'h78000, exp: cos_m(20'h78000)};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x_in      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_b("reset in_ready", in_ready, 1'b1);
    check_b("reset out_valid", out_valid, 1'b0);
    check_v("reset cos_out", cos_out, 20'h00000);
    check_v("reset mul_a", mul_a, 20'h00000);
    check_v("reset mul_b", mul_b, 20'h00000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      drive_accept(vecs[i].x);
      wait_done(res, lat);
      check_v($sformatf("vec%0d cos_out", i), res, vecs[i].exp);
      check_i($sformatf("vec%0d latency", i), lat, 5);
      @(posedge clk);
      #1;
    end

    // Horner intermediates for x = 1.0.
    drive_accept(20'h10000);
    @(negedge clk);
    @(negedge clk);
    check_v("x1 z on mul_b", mul_b, 20'h10000);
    check_v("x1 C3 on mul_a", mul_a, 20'hFFFA5);
    @(negedge clk);
    check_v("x1 acc k2", mul_a, 20'h00A50);
    @(negedge clk);
    check_v("x1 acc k1", mul_a, 20'hF8A50);
    wait_done(res, lat);
    check_v("x1 cos_out", res, 20'h08A50);
    @(posedge clk);
    #1;

    // Large x: squared value overflows Q4.16.
    drive_accept(20'h78000);
    @(negedge clk);
    check_v("x7.5 square operand", mul_a, 20'h78000);
    @(negedge clk);
`ifdef COS_SAT_EN
    check_v("x7.5 z saturated", mul_b, 20'h7FFFF);
`else
    check_v("x7.5 z wrapped", mul_b, 20'h84000);
`endif
    wait_done(res, lat);
    check_v("x7.5 cos_out", res, cos_m(20'h78000));
    @(posedge clk);
    #1;

    // Back-pressure: hold result, ignore a new in_valid until handshake.
    out_ready = 1'b0;
    drive_accept(20'h10000);
    wait_done(res, lat);
    check_v("bp cos_out", res, 20'h08A50);
    in_valid = 1'b1;
    x_in     = 20'h00000;
    held     = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (!out_valid || in_ready || cos_out !== 20'h08A50) held = 1'b0;
    end
    check_b("bp output held", held, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    check_b("bp in_ready after handshake", in_ready, 1'b1);
    check_b("bp out_valid cleared", out_valid, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(res, lat);
    check_v("bp second x result", res, 20'h10000);
    check_i("bp second x latency", lat, 5);
    @(posedge clk);
    #1;

    // Throughput with in_valid and out_ready held high.
    in_valid = 1'b1;
    x_in     = 20'h00000;
    first    = -1;
    second   = -1;
    prev     = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid && !prev) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      prev = out_valid;
    end
    in_valid = 1'b0;
    check_i("throughput period", second - first, 6);
    repeat (10) @(posedge clk);
    #1;
    check_b("drain in_ready", in_ready, 1'b1);

    // Reset during the second HORN cycle aborts the evaluation.
    drive_accept(20'h10000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_b("abort in_ready", in_ready, 1'b1);
    check_b("abort out_valid", out_valid, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_b("abort no result", seen, 1'b0);
    @(posedge clk);
    #1;
    drive_accept(20'h00000);
    wait_done(res, lat);
    check_v("after abort cos_out", res, 20'h10000);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
